// File: rtl/sipo_collector_pkg.sv
// Shared types and helpers for the serial-to-parallel collector.
package sipo_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} sipo_state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_collector_if.sv
// Serial input stream and parallel word outputs of the collector.
interface sipo_collector_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic [WIDTH-1:0] q;
  logic             load;
  logic             parity_err;
  logic             frame_err;
  logic             busy;

  modport master (
    output sin, sin_valid, sof,
    input  q, load, parity_err, frame_err, busy
  );

  modport slave (
    input  sin, sin_valid, sof,
    output q, load, parity_err, frame_err, busy
  );
endinterface

// File: rtl/sipo_collector_bit_shifter.sv
// WIDTH-bit shift register; exposes the next value so the word can be
// captured on the same edge as its last bit.
module bit_shifter #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear_load,
  input  logic             sin,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_nxt
);

  always_comb begin
    data_nxt = data;
    if (clear_load) begin
      data_nxt = '0;
      if (MSB_FIRST) data_nxt[0] = sin;
      else           data_nxt[WIDTH-1] = sin;
    end else if (shift_en) begin
      if (MSB_FIRST) data_nxt = {data[WIDTH-2:0], sin};
      else           data_nxt = {sin, data[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data <= '0;
    else      data <= data_nxt;
  end

endmodule

// File: rtl/sipo_collector.sv
// Collects a qualified serial stream into WIDTH-bit words with optional
// even-parity check; emits one registered load pulse per good word.
module sipo_collector #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY    = 1'b0
) (
  input logic            clk,
  input logic            rst,
  sipo_collector_if.slave bus
);
  import sipo_pkg::*;

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sipo_state_t      state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             par, par_nxt;
  logic [WIDTH-1:0] q, q_nxt, sh_data, sh_next;
  logic             load, load_nxt;
  logic             perr, perr_nxt;
  logic             ferr, ferr_nxt;
  logic             shift_en, clear_load;
  logic             start;

  assign start = bus.sin_valid & bus.sof;

  bit_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .clear_load (clear_load),
    .sin        (bus.sin),
    .data       (sh_data),
    .data_nxt   (sh_next)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    par_nxt    = par;
    q_nxt      = q;
    load_nxt   = 1'b0;
    perr_nxt   = 1'b0;
    ferr_nxt   = 1'b0;
    shift_en   = 1'b0;
    clear_load = 1'b0;
    // A sof bit always restarts the word, even when it aborts one in flight.
    if (start) begin
      clear_load = 1'b1;
      state_nxt  = SHIFT;
      cnt_nxt    = CW'(1);
      par_nxt    = bus.sin;
      ferr_nxt   = (state != IDLE);
    end else if (bus.sin_valid) begin
      case (state)
        SHIFT: begin
          shift_en = 1'b1;
          cnt_nxt  = cnt + 1'b1;
          par_nxt  = par ^ bus.sin;
          if (cnt == LAST) begin
            if (PARITY) begin
              state_nxt = PAR;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
              q_nxt     = sh_next;
              load_nxt  = 1'b1;
            end
          end
        end
        PAR: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (par ^ bus.sin) begin
            perr_nxt = 1'b1;
          end else begin
            q_nxt    = sh_data;
            load_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      par   <= 1'b0;
      q     <= '0;
      load  <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      par   <= par_nxt;
      q     <= q_nxt;
      load  <= load_nxt;
      perr  <= perr_nxt;
      ferr  <= ferr_nxt;
    end
  end

  assign bus.q          = q;
  assign bus.load       = load;
  assign bus.parity_err = perr;
  assign bus.frame_err  = ferr;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/sipo_collector.md
# sipo_collector

Serial-to-parallel collector that assembles a qualified serial bit stream into WIDTH-bit words, with optional parity checking. Sits directly upstream of the 4-bit parallel-load register.
- Its `q`/`load` outputs drive that register's `in`/`load` inputs.
- Each completed, error-free word produces exactly one single-cycle `load` pulse.
- `q` is held stable between words.

## Interface
- `WIDTH`, 4: data bits per word (≥2).
- `MSB_FIRST`, 1: 1 = first accepted bit lands in `q[WIDTH-1]`; 0 = first bit lands in `q[0]`.
- `PARITY`, 0: 0 = no parity bit; 1 = one even-parity bit follows the data bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sin`  in  1  serial data bit, sampled only when `sin_valid`=1.
- `sin_valid`  in  1  qualifies `sin` this cycle.
- `sof`  in  1  start of frame; meaningful only with `sin_valid`=1; marks this bit as data bit 0.
- `q`  out  WIDTH  last completed word.
- `load`  out  1  one-cycle strobe; `q` holds a new word.
- `parity_err`  out  1  one-cycle strobe; parity mismatch, word discarded.
- `frame_err`  out  1  one-cycle strobe; `sof` arrived mid-word, partial word discarded.
- `busy`  out  1  a word is partially collected.

## Operation
States:
- **IDLE**: waits for `sin_valid`&`sof`. Valid bits without `sof` are dropped.
- **SHIFT**: collects data bits 1..WIDTH-1. Bit counter `cnt` counts accepted bits.
- **PAR**: present only when `PARITY`=1; waits for one valid parity bit.

Transitions:
- IDLE → SHIFT on `sin_valid`&`sof`. `sin` is stored as bit 0 and `cnt`=1.
- SHIFT: each valid bit is shifted in (direction set by `MSB_FIRST`) and `cnt` increments.
- When the WIDTH-th bit is accepted:
  - `PARITY`=0: next state IDLE; shift-register contents move to `q`; `load`=1.
  - `PARITY`=1: next state PAR.
- PAR, on a valid bit, next state is IDLE:
  - Even parity holds (XOR of data bits and parity bit = 0): update `q`, `load`=1.
  - Otherwise: `q` unchanged, `parity_err`=1, `load`=0.
- `sof` in SHIFT or PAR with `sin_valid`:
  - `frame_err`=1 and the partial word is discarded.
  - The same bit starts a new word (bit 0, `cnt`=1, state SHIFT). No cycle is lost.
- `sof` with `sin_valid`=0 is ignored in all states.
- `sin_valid`=0 cycles inside a word stall collection indefinitely. No timeout.
- `busy`=1 in SHIFT and PAR.

## Timing
- Reset (`rst`=0, asynchronous): `q`=0, `load`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state IDLE, `cnt`=0.
- Reset mid-word discards the partial word. `q` returns to 0.
- Reset release is synchronised externally; the block samples only on `clk` rising edges.
- All outputs are registered. If the last bit (data or parity) is accepted at edge N:
  - `q`/`load` (or `parity_err`) are valid after edge N and deassert after edge N+1.
  - The downstream register captures at edge N+1.
- `q` changes only in the same cycle `load` rises.
- Back-to-back words are allowed: a `sof` bit accepted at edge N+1 does not disturb `load` from edge N.
- `frame_err` asserts the cycle after the offending `sof` edge.
- Throughput: one word per WIDTH (+`PARITY`) valid bits.

## Structure
- Shared package `sipo_pkg`:
  - state enum `sipo_state_t` {IDLE, SHIFT, PAR};
  - a width function for `cnt`: `$clog2(WIDTH+1)`.
- One natural sub-module: `bit_shifter`, a WIDTH-bit shift register with direction parameter, `shift_en`, `clear_load` and serial input. The FSM, counter, parity accumulator and output register live in the top.

## Test plan
All cases use `WIDTH`=4.
1. `MSB_FIRST`=1, `PARITY`=0; bits 1,0,0,1 with `sof` on the first → `q`=4'b1001, `load` high exactly one cycle, after the 4th bit's edge.
2. `MSB_FIRST`=0; same bits → `q`=4'b1001 (symmetric); bits 1,1,0,0 → `q`=4'b0011.
3. `PARITY`=1:
   - data 1,0,1,1 with parity 1 → `load`, `q`=4'b1011.
   - data 1,0,1,1 with parity 0 → `parity_err` pulse, `q` keeps its previous value, no `load`.
4. `sof` on the 3rd bit of a word, followed by 3 more bits → `frame_err` pulse; the next `load` carries the new 4-bit word; no `load` for the aborted word.
5. Valid bits interleaved with random `sin_valid`=0 gaps; `sof`-less bits sent while IDLE → `q`/`load` identical to the gap-free case; IDLE bits ignored.
6. `rst` asserted after 2 bits of a word → all outputs 0 immediately (asynchronous); after release, a full new word loads correctly; two back-to-back words give two `load` pulses exactly 4 valid cycles apart.
